// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci LCD demo sequencer.
// The optional button debounce filter is enabled by defining FIB_DEBOUNCE_EN.
package fib_pkg;

    localparam int FIB_WIDTH         = 16;
    localparam int FIB_STEP_DIV      = 50_000_000;
    localparam int FIB_DEBOUNCE_BITS = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        SHOW   = 3'd4,
        WAIT   = 3'd5,
        HALT   = 3'd6
    } fib_seq_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer, optional stability filter, rising-edge detect.
// Defining FIB_DEBOUNCE_EN inserts a 2^16-cycle stability filter before the edge detector.
module btn_sync_edge
    import fib_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic last_r;

    // Two-stage synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef FIB_DEBOUNCE_EN
    logic [FIB_DEBOUNCE_BITS-1:0] db_cnt_r;
    logic                         stable_r;

    // Adopt a new level only once it has held for the full counter range
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt_r <= '0;
            stable_r <= 1'b0;
        end else if (sync2_r == stable_r) begin
            db_cnt_r <= '0;
        end else if (&db_cnt_r) begin
            db_cnt_r <= '0;
            stable_r <= sync2_r;
        end else begin
            db_cnt_r <= db_cnt_r + FIB_DEBOUNCE_BITS'(1);
        end
    end

    assign level_s = stable_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous conditioned level for the edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= 1'b0;
        end else begin
            last_r <= level_s;
        end
    end

    // The sequencer registers this, which forms the third latency stage
    assign rise = level_s & ~last_r;

endmodule

// File: rtl/fib_sequencer.sv
// Control sequencer for the Fibonacci datapath: seed loads, paced stepping,
// wrap-around halt and valid/ready hand-off to the LCD. See btn_sync_edge for FIB_DEBOUNCE_EN.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int WIDTH    = FIB_WIDTH,
    parameter int STEP_DIV = FIB_STEP_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       switches,
    input  logic             set_a,
    input  logic             set_b,
    input  logic             run,
    input  logic [WIDTH-1:0] fib_value,
    output logic             fib_load_a,
    output logic             fib_load_b,
    output logic             fib_step,
    output logic [WIDTH-1:0] fib_seed,
    output logic             disp_valid,
    output logic [WIDTH-1:0] disp_data,
    input  logic             disp_ready,
    output logic             ovf
);

    localparam int CNT_W = $clog2(STEP_DIV);

    fib_seq_state_t   state_r, state_s;
    logic             ev_a_s, ev_b_s;
    logic [WIDTH-1:0] seed_ext_s;
    logic             load_a_r, load_a_s;
    logic             load_b_r, load_b_s;
    logic             step_r, step_s;
    logic             valid_r, valid_s;
    logic             ovf_r, ovf_s;
    logic             pend_b_r, pend_b_s;
    logic             from_load_r, from_load_s;
    logic [WIDTH-1:0] seed_r, seed_s;
    logic [WIDTH-1:0] disp_data_r, disp_data_s;
    logic [WIDTH-1:0] prev_r, prev_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    btn_sync_edge u_btn_a (.clk(clk), .reset(reset), .btn(set_a), .rise(ev_a_s));
    btn_sync_edge u_btn_b (.clk(clk), .reset(reset), .btn(set_b), .rise(ev_b_s));

    assign seed_ext_s = {{(WIDTH-4){1'b0}}, switches};

    // State and all output/datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            load_a_r    <= 1'b0;
            load_b_r    <= 1'b0;
            step_r      <= 1'b0;
            valid_r     <= 1'b0;
            ovf_r       <= 1'b0;
            pend_b_r    <= 1'b0;
            from_load_r <= 1'b0;
            seed_r      <= '0;
            disp_data_r <= '0;
            prev_r      <= '0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_s;
            load_a_r    <= load_a_s;
            load_b_r    <= load_b_s;
            step_r      <= step_s;
            valid_r     <= valid_s;
            ovf_r       <= ovf_s;
            pend_b_r    <= pend_b_s;
            from_load_r <= from_load_s;
            seed_r      <= seed_s;
            disp_data_r <= disp_data_s;
            prev_r      <= prev_s;
            cnt_r       <= cnt_s;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_s     = state_r;
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        ovf_s       = ovf_r;
        pend_b_s    = pend_b_r;
        from_load_s = from_load_r;
        seed_s      = seed_r;
        disp_data_s = disp_data_r;
        prev_s      = prev_r;
        cnt_s       = cnt_r;
        case (state_r)
            IDLE, HALT: begin
                // A wins a simultaneous press; B waits for the next IDLE cycle
                if (ev_a_s) begin
                    load_a_s    = 1'b1;
                    pend_b_s    = pend_b_r | ev_b_s;
                    seed_s      = seed_ext_s;
                    disp_data_s = seed_ext_s;
                    prev_s      = seed_ext_s;
                    ovf_s       = 1'b0;
                    from_load_s = 1'b1;
                    state_s     = SHOW;
                end else if (ev_b_s || pend_b_r) begin
                    load_b_s    = 1'b1;
                    pend_b_s    = 1'b0;
                    seed_s      = seed_ext_s;
                    disp_data_s = seed_ext_s;
                    prev_s      = seed_ext_s;
                    ovf_s       = 1'b0;
                    from_load_s = 1'b1;
                    state_s     = SHOW;
                end else if ((state_r == IDLE) && run) begin
                    state_s = STEP;
                end else begin
                    state_s = state_r;
                end
            end
            STEP:   state_s = SETTLE;
            SETTLE: state_s = CHECK;
            CHECK: begin
                if (fib_value < prev_r) begin
                    ovf_s   = 1'b1;
                    state_s = HALT;
                end else begin
                    prev_s      = fib_value;
                    disp_data_s = fib_value;
                    from_load_s = 1'b0;
                    state_s     = SHOW;
                end
            end
            SHOW: begin
                if (!disp_ready) begin
                    state_s = SHOW;
                end else if (from_load_r) begin
                    state_s = IDLE;
                end else begin
                    cnt_s   = CNT_W'(STEP_DIV - 1);
                    state_s = WAIT;
                end
            end
            WAIT: begin
                // Leaving as the count reaches zero gives a STEP_DIV+3 cycle period
                cnt_s = cnt_r - CNT_W'(1);
                if (!run) begin
                    state_s = IDLE;
                end else if (cnt_r <= CNT_W'(1)) begin
                    state_s = STEP;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
        step_s  = (state_s == STEP);
        valid_s = (state_s == SHOW);
    end

    assign fib_load_a = load_a_r;
    assign fib_load_b = load_b_r;
    assign fib_step   = step_r;
    assign fib_seed   = seed_r;
    assign disp_valid = valid_r;
    assign disp_data  = disp_data_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer with a behavioural A/B Fibonacci datapath.
// STEP_DIV is 4, so a running sequence yields one value every 7 cycles.
`timescale 1ns/1ps
module tb_fib_sequencer;
    import fib_pkg::*;

    localparam int W   = 16;
    localparam int DIV = 4;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic [3:0]   switches   = 4'd0;
    logic         set_a      = 1'b0;
    logic         set_b      = 1'b0;
    logic         run        = 1'b0;
    logic         disp_ready = 1'b1;
    logic [W-1:0] fib_value;
    logic         fib_load_a, fib_load_b, fib_step, disp_valid, ovf;
    logic [W-1:0] fib_seed, disp_data;

    logic [W-1:0] dp_a = 16'd0;
    logic [W-1:0] dp_b = 16'd0;

    int n_checks = 0;
    int n_errors = 0;

    int cyc      = 0;
    int la_cnt   = 0;
    int lb_cnt   = 0;
    int step_cnt = 0;
    int la_cyc   = 0;
    int lb_cyc   = 0;
    logic [W-1:0] xfer_data[$];
    int           xfer_cyc[$];

    fib_sequencer #(.WIDTH(W), .STEP_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .switches(switches), .set_a(set_a), .set_b(set_b),
        .run(run), .fib_value(fib_value), .fib_load_a(fib_load_a), .fib_load_b(fib_load_b),
        .fib_step(fib_step), .fib_seed(fib_seed), .disp_valid(disp_valid),
        .disp_data(disp_data), .disp_ready(disp_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: B holds the newest value
    always @(posedge clk) begin
        if (fib_load_a) dp_a <= fib_seed;
        if (fib_load_b) dp_b <= fib_seed;
        if (fib_step) begin
            dp_a <= dp_b;
            dp_b <= dp_a + dp_b;
        end
    end
    assign fib_value = dp_b;

    // Event monitor sampling pre-edge values
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fib_load_a) begin la_cnt <= la_cnt + 1; la_cyc <= cyc; end
        if (fib_load_b) begin lb_cnt <= lb_cnt + 1; lb_cyc <= cyc; end
        if (fib_step)   step_cnt <= step_cnt + 1;
        if (disp_valid && disp_ready) begin
            xfer_data.push_back(disp_data);
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic a, input logic b, output int at_cyc);
        @(negedge clk);
        set_a  = a;
        set_b  = b;
        at_cyc = cyc;
        cycles(4);
        set_a = 1'b0;
        set_b = 1'b0;
        cycles(6);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_value({pfx, "_load_a"}, {31'd0, fib_load_a}, 32'd0);
        check_value({pfx, "_load_b"}, {31'd0, fib_load_b}, 32'd0);
        check_value({pfx, "_step"},   {31'd0, fib_step},   32'd0);
        check_value({pfx, "_valid"},  {31'd0, disp_valid}, 32'd0);
        check_value({pfx, "_ovf"},    {31'd0, ovf},        32'd0);
        check_value({pfx, "_seed"},   {16'd0, fib_seed},   32'd0);
        check_value({pfx, "_data"},   {16'd0, disp_data},  32'd0);
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int i;
        i = 0;
        while (!disp_valid && i < bound) begin @(negedge clk); i++; end
        check_value(tag, {31'd0, disp_valid}, 32'd1);
    endtask

    task automatic wait_ovf(input int bound, input string tag);
        int i;
        i = 0;
        while (!ovf && i < bound) begin @(negedge clk); i++; end
        check_value(tag, {31'd0, ovf}, 32'd1);
    endtask

    task automatic wait_xfers(input int target, input int bound, input string tag);
        int i;
        i = 0;
        while (xfer_data.size() < target && i < bound) begin @(negedge clk); i++; end
        check_value(tag, 32'(xfer_data.size() >= target), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n0, s0, x0, las, lbs, sc;
        logic [W-1:0] ea, eb, en;

        // Reset state
        #2 reset = 1'b0;
        #1 check_zero_outputs("reset");
        cycles(3);
        reset = 1'b1;
        cycles(2);

        // 1: seed loads
        switches = 4'd1;
        press(1'b1, 1'b0, t0);
        check_value("la_latency", 32'(la_cyc - t0), 32'd3);
        check_value("la_count", 32'(la_cnt), 32'd1);
        check_value("lb_none", 32'(lb_cnt), 32'd0);
        check_value("seed_a", {16'd0, fib_seed}, 32'd1);
        check_value("xfer_after_a", 32'(xfer_data.size()), 32'd1);
        press(1'b0, 1'b1, t0);
        check_value("lb_latency", 32'(lb_cyc - t0), 32'd3);
        check_value("lb_count", 32'(lb_cnt), 32'd1);
        check_value("la_single", 32'(la_cnt), 32'd1);
        check_value("disp_seed", {16'd0, disp_data}, 32'd1);
        check_value("ovf_after_load", {31'd0, ovf}, 32'd0);
        check_value("idle_valid", {31'd0, disp_valid}, 32'd0);

        // 2 and 3: run from 1,1 until the wrap
        n0 = xfer_data.size();
        s0 = step_cnt;
        run = 1'b1;
        wait_ovf(400, "ovf_wait");
        cycles(1);
        check_value("seq_len", 32'(xfer_data.size() - n0), 32'd22);
        ea = 16'd1;
        eb = 16'd1;
        for (int i = 0; i < 22; i++) begin
            en = ea + eb;
            ea = eb;
            eb = en;
            if (n0 + i < xfer_data.size())
                check_value($sformatf("seq%0d", i), {16'd0, xfer_data[n0 + i]}, {16'd0, en});
        end
        for (int i = 1; i < 5; i++) begin
            if (n0 + i < xfer_cyc.size())
                check_value($sformatf("period%0d", i), 32'(xfer_cyc[n0 + i] - xfer_cyc[n0 + i - 1]), 32'd7);
        end
        check_value("halt_state", 32'(dut.state_r), 32'(HALT));
        check_value("halt_data", {16'd0, disp_data}, 32'd46368);
        check_value("steps_to_wrap", 32'(step_cnt - s0), 32'd23);
        cycles(20);
        check_value("halt_no_step", 32'(step_cnt - s0), 32'd23);
        check_value("halt_valid", {31'd0, disp_valid}, 32'd0);

        // 4: loads from HALT, then a stalled handshake
        run = 1'b0;
        switches = 4'd1;
        press(1'b1, 1'b0, t0);
        check_value("ovf_cleared", {31'd0, ovf}, 32'd0);
        press(1'b0, 1'b1, t0);
        disp_ready = 1'b0;
        run = 1'b1;
        wait_valid(20, "stall_show");
        s0 = step_cnt;
        x0 = xfer_data.size();
        sc = 0;
        for (int i = 0; i < 10; i++) begin
            if (disp_valid && disp_data == 16'd2) sc++;
            @(negedge clk);
        end
        check_value("stall_stable", 32'(sc), 32'd10);
        check_value("stall_no_step", 32'(step_cnt - s0), 32'd0);
        check_value("stall_no_xfer", 32'(xfer_data.size() - x0), 32'd0);
        run = 1'b0;
        disp_ready = 1'b1;
        cycles(3);
        check_value("stall_one_xfer", 32'(xfer_data.size() - x0), 32'd1);
        if (x0 < xfer_data.size())
            check_value("stall_xfer_data", {16'd0, xfer_data[x0]}, 32'd2);
        check_value("stall_valid_low", {31'd0, disp_valid}, 32'd0);

        // 5: simultaneous press, then a press during WAIT
        switches = 4'd5;
        las = la_cnt;
        lbs = lb_cnt;
        press(1'b1, 1'b1, t0);
        check_value("both_la_latency", 32'(la_cyc - t0), 32'd3);
        check_value("both_order", 32'((lb_cyc - la_cyc) >= 1 && (lb_cyc - la_cyc) <= 3), 32'd1);
        check_value("both_la_count", 32'(la_cnt - las), 32'd1);
        check_value("both_lb_count", 32'(lb_cnt - lbs), 32'd1);
        check_value("both_seed", {16'd0, fib_seed}, 32'd5);
        run = 1'b1;
        wait_valid(20, "wait_press_show");
        las = la_cnt;
        lbs = lb_cnt;
        set_a = 1'b1;
        set_b = 1'b1;
        cycles(4);
        set_a = 1'b0;
        set_b = 1'b0;
        cycles(4);
        check_value("wait_drop_a", 32'(la_cnt - las), 32'd0);
        check_value("wait_drop_b", 32'(lb_cnt - lbs), 32'd0);
        check_value("wait_drop_seed", {16'd0, fib_seed}, 32'd5);
        run = 1'b0;
        cycles(10);

        // 6: reset mid-WAIT, resume, then reset in HALT
        run = 1'b1;
        wait_valid(20, "rst_wait_show");
        cycles(2);
        reset = 1'b0;
        #1 check_zero_outputs("rst_wait");
        run = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(2);
        switches = 4'd1;
        press(1'b1, 1'b0, t0);
        press(1'b0, 1'b1, t0);
        check_value("resume_seed", {16'd0, disp_data}, 32'd1);
        n0 = xfer_data.size();
        run = 1'b1;
        wait_xfers(n0 + 1, 30, "resume_xfer");
        if (n0 < xfer_data.size())
            check_value("resume_first", {16'd0, xfer_data[n0]}, 32'd2);
        wait_ovf(400, "resume_ovf");
        reset = 1'b0;
        #1 check_zero_outputs("rst_halt");
        run = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(2);
        switches = 4'd3;
        press(1'b1, 1'b0, t0);
        check_value("post_halt_data", {16'd0, disp_data}, 32'd3);
        check_value("post_halt_seed", {16'd0, fib_seed}, 32'd3);
        check_value("post_halt_ovf", {31'd0, ovf}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Control sequencer for the Fibonacci datapath on the LCD demo board. It turns the raw SetA/SetB buttons and the 4-bit switch bank into one-cycle seed-load strobes, and steps the datapath at a programmable rate while `run` is high. It detects 16-bit wrap-around and halts on it. Each new value is handed to the LCD controller through a valid/ready handshake.

## Interface
- `WIDTH`, 16: datapath value width.
- `STEP_DIV`, 50_000_000: clock cycles between steps; minimum 2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `switches` in 4: seed value, zero-extended to `WIDTH`.
- `set_a` in 1: raw button, asynchronous to `clk`.
- `set_b` in 1: raw button, asynchronous to `clk`.
- `run` in 1: level; enables stepping.
- `fib_value` in WIDTH: current datapath output.
- `fib_load_a` out 1: one-cycle strobe; datapath loads A from `fib_seed`.
- `fib_load_b` out 1: one-cycle strobe; datapath loads B from `fib_seed`.
- `fib_step` out 1: one-cycle strobe; datapath computes A+B and shifts.
- `fib_seed` out WIDTH: registered seed.
- `disp_valid` out 1: display data valid.
- `disp_data` out WIDTH: value for the LCD.
- `disp_ready` in 1: LCD controller accepts data.
- `ovf` out 1: sticky wrap-around flag.

## Operation
- Buttons pass through a 2-flop synchronizer, then a rising-edge detector. Each press yields one event.
- States:
  - `IDLE`: waits for a load or run; accepts loads.
  - `STEP`: `fib_step`=1 for one cycle.
  - `SETTLE`: one cycle for the datapath to update.
  - `CHECK`: compares `fib_value` with `prev`.
  - `SHOW`: holds `disp_valid` until accepted.
  - `WAIT`: counts down the step interval.
  - `HALT`: stopped on overflow; accepts loads.
- Loads:
  - Accepted only in `IDLE` or `HALT`.
  - A load drives `fib_seed`={0,switches}, pulses the matching strobe and updates `disp_data`/`prev` to the seed.
  - A load raises `disp_valid` through one `SHOW` pass, then returns to `IDLE`.
  - A load from `HALT` clears `ovf`.
- Simultaneous `set_a`/`set_b` events: A is served first. B is latched as pending and served on the next `IDLE` cycle.
- Button events in any other state are dropped.
- `IDLE` → `STEP` when `run`=1 and no load is pending.
- `CHECK`:
  - If `fib_value` < `prev` (unsigned), the value wrapped: `ovf`←1 and go to `HALT`. `disp_data` keeps the last good value.
  - Otherwise `prev`,`disp_data`←`fib_value` and go to `SHOW`.
- `SHOW`: `disp_valid`=1 and `disp_data` stable until the cycle `disp_valid`&&`disp_ready`. Then go to `WAIT`, loading the counter with `STEP_DIV`-1.
- `WAIT`:
  - Decrements the counter.
  - At 0: go to `STEP` if `run`=1, else `IDLE`.
  - `run`=0 mid-count → `IDLE` next cycle.
- The counter width is `$clog2(STEP_DIV)`. Arithmetic is unsigned `WIDTH`-bit; the wrap test is the only overflow detection.

## Timing
- Reset (async assert, sync release): state `IDLE`; all strobes, `disp_valid` and `ovf` at 0; `fib_seed`, `disp_data`, `prev`, counter and pending at 0.
- Button edge to strobe: 3 cycles (2 sync + 1 edge register).
- `fib_step` to `CHECK` sample: 2 cycles.
- Step period with `disp_ready` tied high: `STEP_DIV`+3 cycles.
- `disp_ready` may be high before `disp_valid`. The transfer completes in the first `SHOW` cycle.
- Reset mid-handshake drops `disp_valid` immediately. No transfer is counted.

## Configuration
- `FIB_DEBOUNCE_EN` defined:
  - Each synchronized button must be stable for 2^16 cycles before its edge detector sees the change.
  - Adds 65536 cycles of edge latency.
- Undefined: no filter; edge latency is 3 cycles.

## Structure
- Shared package `fib_pkg`: state enum `fib_seq_state_t`, `FIB_WIDTH`=16, default `STEP_DIV`.
- One sub-module `btn_sync_edge` (synchronizer, optional debounce, edge detect), instantiated twice.

## Test plan
1. Seed loads: switches=1, press `set_a`, then `set_b` (`STEP_DIV`=4, `disp_ready`=1) → `fib_load_a` then `fib_load_b` single pulses; `disp_data`=1, `ovf`=0.
2. Run from seeds 1,1 → `disp_data` sequence 2,3,5,8,13, one value per 7 cycles.
3. Overflow: run from 1,1 to 46368; next step wraps to 9489 → `ovf`=1, state `HALT`, `disp_data` stays 46368, no further `fib_step`.
4. Handshake: hold `disp_ready`=0 for 10 cycles in `SHOW` → `disp_valid` and `disp_data` stable for 10 cycles, no `fib_step`. Release → exactly one transfer.
5. Simultaneous press of `set_a`/`set_b` → `fib_load_a` first, `fib_load_b` no more than 3 cycles later. Press during `WAIT` → no strobe.
6. Assert `reset` mid-`WAIT` and in `HALT` → all outputs 0 asynchronously; normal operation resumes from `IDLE`.
